ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Single-port external SRAM controller and arbiter feeding `ram_pause` into the pipeline pause/hazard unit.
- Serves the IF-stage instruction fetch and the MEM-stage load/store through one shared SRAM with a fixed multi-cycle access time.
- Holds the pipeline with `ram_pause` until every access requested for the current pipeline cycle is complete.
- MEM access always goes before IF fetch, so a load/store never stalls behind a fetch of a younger instruction.

Parameters:
- ADDR_W, 18, SRAM/word address width.
- DATA_W, 16, instruction and data word width.
- ACC_CYCLES, 2, clocks per SRAM access; legal range 2..15.
- NOP_INST, 16'h0800, value presented on `if_inst` after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: one clock, synchronous, active-high.
- if_req  in  1  IF stage requests a fetch this pipeline cycle.
- if_addr  in  ADDR_W  PC word address.
- if_inst  out  DATA_W  fetched instruction, registered.
- mem_re  in  1  MEM stage load request.
- mem_we  in  1  MEM stage store request.
- mem_addr  in  ADDR_W  load/store word address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data, registered.
- ram_pause  out  1  1 = pipeline must hold; consumed by pause control.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_data_oe  out  1  1 = top level drives `sram_wdata` onto the SRAM data bus.
- sram_rdata  in  DATA_W  SRAM read data.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Reset (any cycle, including mid-access):
  - state=IDLE, cnt=0, ram_pause=0.
  - if_inst=NOP_INST, mem_rdata=0.
  - sram_ce_n=oe_n=we_n=1, sram_data_oe=0, sram_addr=0, sram_wdata=0.
  - An aborted write leaves SRAM contents undefined at that address only.
- All outputs are registered or decoded from state; there is no combinational path from `if_*`/`mem_*` inputs to `ram_pause`.
- `ram_pause` = 1 in states DATA and INST, 0 in IDLE and DONE.
- State IDLE:
  - If mem_re|mem_we: latch mem_addr, mem_wdata, and op (write wins if both are set); cnt=0; go to DATA.
  - Else if if_req: latch if_addr, cnt=0, go to INST.
  - Else stay in IDLE.
  - The request is sampled in IDLE; the first pause-high cycle is the next one.
- State DATA, lasting ACC_CYCLES clocks:
  - ce_n=0; sram_addr=latched mem_addr.
  - Read: oe_n=0, we_n=1, data_oe=0.
  - Write: oe_n=1, data_oe=1, sram_wdata=latched data; we_n=0 on cycles cnt=0..ACC_CYCLES-2 and 1 on the last cycle (address/data hold).
  - Last cycle (cnt=ACC_CYCLES-1): a read registers sram_rdata into mem_rdata at this edge. Then latch if_addr and go to INST if if_req=1, else go to DONE.
- State INST, lasting ACC_CYCLES clocks:
  - ce_n=0, oe_n=0, we_n=1, data_oe=0, sram_addr=latched PC.
  - Last cycle: register sram_rdata into if_inst, go to DONE.
- State DONE: exactly one cycle with ram_pause=0 so the pipeline advances; then go to IDLE. Requests seen in DONE are ignored and are re-sampled in IDLE.
- Cycle counts:
  - Fetch only: IDLE→INST×ACC→DONE; pause high for ACC_CYCLES clocks.
  - Fetch plus load/store: pause high for 2×ACC_CYCLES clocks.
  - No request: pause stays 0.
- `cnt` is 4 bits, clears on every state entry, and never wraps past ACC_CYCLES-1.
- `if_inst` and `mem_rdata` hold their value until the next completed access of the same kind.
- A store never alters `mem_rdata`.
- When not in DATA/INST: ce_n=oe_n=we_n=1, data_oe=0, sram_addr holds its last value.

Test Plan:
- Reset, then if_req=1, if_addr=0x00010, SRAM[0x10]=0x6801, ACC=2 → pause high for exactly 2 clocks; if_inst=0x6801 in the DONE cycle; no we_n low.
- mem_re=1, mem_addr=0x0200 (SRAM=0xBEEF), if_req=1, PC=0x11 (SRAM=0x4A05) → pause high 4 clocks; sram_addr sequence 0x200,0x200,0x11,0x11; mem_rdata=0xBEEF, if_inst=0x4A05.
- mem_we=1, addr=0x0300, wdata=0x1234, if_req=0 → we_n low 1 clock, then high 1 clock with addr/data held; data_oe=1 both clocks; pause high 2 clocks; a later read of 0x300 returns 0x1234.
- mem_re=mem_we=1 → write performed; mem_rdata unchanged.
- rst asserted during the 2nd DATA cycle of a write → next cycle: IDLE, pause=0, we_n=1, if_inst=0x0800.
- ACC_CYCLES=4, fetch-only loop over 3 PCs → each fetch costs 5 clocks (4 paused + 1 DONE); pause duty measured at 4/5.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port SRAM controller serving MEM load/store ahead of IF fetch, stalling the pipeline via ram_pause
module ram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int ACC_CYCLES = 2,
  parameter logic [DATA_W-1:0] NOP_INST = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_pause,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_data_oe,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  typedef enum logic [1:0] {IDLE, DATA, INST, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic op_we, last, busy;
  assign last = cnt == 4'(ACC_CYCLES - 1);
  assign busy = state == DATA || state == INST;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      op_we <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
      if_inst <= NOP_INST;
      mem_rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? 4'd0 : cnt + 4'(busy);
      if (state == IDLE && (mem_re || mem_we)) begin
        sram_addr <= mem_addr;
        sram_wdata <= mem_wdata;
        op_we <= mem_we;
      end
      if (state_n == INST && state != INST) sram_addr <= if_addr;
      if (state == DATA && last && !op_we) mem_rdata <= sram_rdata;
      if (state == INST && last) if_inst <= sram_rdata;
    end
  end
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = (mem_re || mem_we) ? DATA : if_req ? INST : IDLE;
      DATA: state_n = !last ? DATA : if_req ? INST : DONE;
      INST: state_n = last ? DONE : INST;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    ram_pause = busy;
    sram_ce_n = !busy;
    sram_data_oe = state == DATA && op_we;
    sram_oe_n = !(busy && !sram_data_oe);
    sram_we_n = !(sram_data_oe && !last);
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: transaction-level model of the arbiter checked every cycle, plus directed literal checks
module tb_ram_arbiter;
  localparam int ACC = 2;
  localparam logic [15:0] NOP = 16'h0800;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic if_req = 0, mem_re = 0, mem_we = 0;
  logic [17:0] if_addr = 0, mem_addr = 0;
  logic [15:0] mem_wdata = 0;
  logic [15:0] if_inst, mem_rdata, sram_wdata, sram_rdata;
  logic ram_pause, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [17:0] sram_addr;
  logic c4_if_req = 0, c4_zero = 0;
  logic [17:0] c4_if_addr = 0, c4_zaddr = 0;
  logic [15:0] c4_zdata = 0;
  logic [15:0] c4_if_inst, c4_mem_rdata, c4_sram_wdata, c4_sram_rdata;
  logic c4_pause, c4_data_oe, c4_ce_n, c4_oe_n, c4_we_n;
  logic [17:0] c4_sram_addr;
  logic [15:0] sram [0:1023];
  logic [15:0] shadow [0:1023];
  int total = 0, bad = 0;

  ram_arbiter #(.ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ram_pause(ram_pause), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe), .sram_rdata(sram_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n));

  ram_arbiter #(.ACC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .if_req(c4_if_req), .if_addr(c4_if_addr), .if_inst(c4_if_inst),
    .mem_re(c4_zero), .mem_we(c4_zero), .mem_addr(c4_zaddr), .mem_wdata(c4_zdata),
    .mem_rdata(c4_mem_rdata), .ram_pause(c4_pause), .sram_addr(c4_sram_addr),
    .sram_wdata(c4_sram_wdata), .sram_data_oe(c4_data_oe), .sram_rdata(c4_sram_rdata),
    .sram_ce_n(c4_ce_n), .sram_oe_n(c4_oe_n), .sram_we_n(c4_we_n));

  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[9:0]] : 16'h0;
  assign c4_sram_rdata = (!c4_ce_n && !c4_oe_n) ? sram[c4_sram_addr[9:0]] : 16'h0;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) sram[sram_addr[9:0]] <= sram_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] kind;
    logic last, wr, pause, ce_n, oe_n, we_n, doe;
    logic [17:0] addr;
  } ent_t;
  ent_t cur, q[$];
  logic [17:0] hold;
  logic [15:0] e_inst, e_rdata, m_wd;
  logic armed = 0;

  function automatic ent_t busy_e(input logic [1:0] k, input logic w, input logic l, input logic [17:0] a);
    ent_t e;
    e.kind = k; e.last = l; e.wr = w; e.pause = 1; e.ce_n = 0;
    e.oe_n = w; e.doe = w; e.we_n = !(w && !l); e.addr = a;
    return e;
  endfunction

  function automatic ent_t idle_e(input logic [1:0] k);
    ent_t e;
    e.kind = k; e.last = 0; e.wr = 0; e.pause = 0; e.ce_n = 1;
    e.oe_n = 1; e.doe = 0; e.we_n = 1; e.addr = '0;
    return e;
  endfunction

  task automatic push_phase(input logic [1:0] k, input logic w, input logic [17:0] a);
    for (int i = 0; i < ACC; i++) q.push_back(busy_e(k, w, i == ACC - 1, a));
  endtask

  // Each accepted request expands into its whole expected cycle sequence
  always @(posedge clk) begin
    if (rst) begin
      q.delete(); cur = idle_e(0); hold = '0; e_inst = NOP; e_rdata = '0; armed = 1;
    end else begin
      if (cur.kind == 0) begin
        if (mem_re || mem_we) begin
          m_wd = mem_wdata;
          push_phase(1, mem_we, mem_addr);
        end else if (if_req) begin
          push_phase(2, 0, if_addr);
          q.push_back(idle_e(3));
        end
      end else if (cur.kind == 1 && cur.last) begin
        if (cur.wr) shadow[cur.addr[9:0]] = m_wd;
        else e_rdata = shadow[cur.addr[9:0]];
        if (if_req) push_phase(2, 0, if_addr);
        q.push_back(idle_e(3));
      end else if (cur.kind == 2 && cur.last) e_inst = shadow[cur.addr[9:0]];
      if (cur.pause) hold = cur.addr;
      cur = (q.size() > 0) ? q.pop_front() : idle_e(0);
    end
  end

  always @(negedge clk) if (armed) begin
    chk("pause", ram_pause, cur.pause);
    chk("ce_n", sram_ce_n, cur.ce_n);
    chk("oe_n", sram_oe_n, cur.oe_n);
    chk("we_n", sram_we_n, cur.we_n);
    chk("data_oe", sram_data_oe, cur.doe);
    chk("sram_addr", sram_addr, cur.pause ? cur.addr : hold);
    chk("if_inst", if_inst, e_inst);
    chk("mem_rdata", mem_rdata, e_rdata);
    if (cur.doe) chk("sram_wdata", sram_wdata, m_wd);
  end

  int np, nwe, ndoe, ncyc;
  logic [17:0] seq [0:7];

  task automatic timeout(input string nm);
    total++; bad++;
    $display("FAIL %s: no DONE within cycle budget", nm);
  endtask

  task automatic run_req(input logic re, input logic we, input logic [17:0] ma, input logic [15:0] wd,
                         input logic ir, input logic [17:0] ia);
    logic done = 0;
    mem_re = re; mem_we = we; mem_addr = ma; mem_wdata = wd; if_req = ir; if_addr = ia;
    np = 0; nwe = 0; ndoe = 0; ncyc = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1; ncyc++;
      if (ram_pause) begin
        if (np < 8) seq[np] = sram_addr;
        np++;
        if (!sram_we_n) nwe++;
        if (sram_data_oe) ndoe++;
      end else if (np > 0) done = 1;
    end
    if (!done) timeout("run_req");
    mem_re = 0; mem_we = 0; if_req = 0;
  endtask

  task automatic fetch4(input logic [17:0] pc);
    logic done = 0;
    c4_if_req = 1; c4_if_addr = pc; np = 0; ncyc = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1; ncyc++;
      if (c4_pause) np++;
      else if (np > 0) done = 1;
    end
    if (!done) timeout("fetch4");
    c4_if_req = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int tp, tc;
    for (int i = 0; i < 1024; i++) begin
      sram[i] <= 16'(i * 3 + 1);
      shadow[i] = 16'(i * 3 + 1);
    end
    sram[16'h10] <= 16'h6801; shadow[16'h10] = 16'h6801;
    sram[16'h11] <= 16'h4A05; shadow[16'h11] = 16'h4A05;
    sram[16'h200] <= 16'hBEEF; shadow[16'h200] = 16'hBEEF;
    sram[16'h20] <= 16'h1111; sram[16'h21] <= 16'h2222; sram[16'h22] <= 16'h3333;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst if_inst", if_inst, 16'h0800);
    chk("rst mem_rdata", mem_rdata, 0);
    chk("rst pause", ram_pause, 0);
    chk("rst ce_n", sram_ce_n, 1);
    chk("rst addr", sram_addr, 0);
    run_req(0, 0, 0, 0, 1, 18'h10);
    chk("fetch pause", np, 2);
    chk("fetch cycles", ncyc, 3);
    chk("fetch inst", if_inst, 16'h6801);
    chk("fetch no we", nwe, 0);
    @(posedge clk); #1;
    run_req(1, 0, 18'h200, 0, 1, 18'h11);
    chk("ld+if pause", np, 4);
    chk("ld+if a0", seq[0], 18'h200);
    chk("ld+if a1", seq[1], 18'h200);
    chk("ld+if a2", seq[2], 18'h11);
    chk("ld+if a3", seq[3], 18'h11);
    chk("ld+if rdata", mem_rdata, 16'hBEEF);
    chk("ld+if inst", if_inst, 16'h4A05);
    @(posedge clk); #1;
    run_req(0, 1, 18'h300, 16'h1234, 0, 0);
    chk("st pause", np, 2);
    chk("st we low", nwe, 1);
    chk("st data_oe", ndoe, 2);
    @(posedge clk); #1;
    run_req(1, 0, 18'h300, 0, 0, 0);
    chk("ld back", mem_rdata, 16'h1234);
    @(posedge clk); #1;
    run_req(1, 1, 18'h301, 16'h7777, 0, 0);
    chk("re+we we low", nwe, 1);
    chk("re+we rdata kept", mem_rdata, 16'h1234);
    @(posedge clk); #1;
    run_req(1, 0, 18'h301, 0, 0, 0);
    chk("re+we stored", mem_rdata, 16'h7777);
    @(posedge clk); #1;
    tp = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tp += int'(ram_pause);
    end
    chk("idle pause", tp, 0);
    mem_we = 1; mem_addr = 18'h350; mem_wdata = 16'h5555;
    @(posedge clk); #1;
    chk("abort c0 we", sram_we_n, 0);
    @(posedge clk); #1;
    chk("abort c1 pause", ram_pause, 1);
    rst = 1; mem_we = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("abort pause", ram_pause, 0);
    chk("abort we_n", sram_we_n, 1);
    chk("abort ce_n", sram_ce_n, 1);
    chk("abort inst", if_inst, 16'h0800);
    run_req(0, 0, 0, 0, 1, 18'h11);
    chk("recover inst", if_inst, 16'h4A05);
    @(posedge clk); #1;
    tp = 0; tc = 0;
    for (int i = 0; i < 3; i++) begin
      fetch4(18'h20 + 18'(i));
      chk("acc4 cycles", ncyc, 5);
      chk("acc4 inst", c4_if_inst, 16'h1111 * 16'(i + 1));
      tp += np; tc += ncyc;
    end
    chk("acc4 duty", tp * 5, tc * 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
